// File: rtl/sram_bank_buf_if.sv
// Request/response bundle for the banked SRAM buffer.
// The master side issues requests and pulses clear_start; the slave side is the buffer.
interface sram_bank_buf_if #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 12,
    parameter int NUM_BANKS = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic                 clear_start;
    logic                 rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic [NUM_BANKS-1:0] bank_en;
    logic                 clear_busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, clear_start,
        input  req_ready, rsp_valid, rsp_data, bank_en, clear_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, clear_start,
        output req_ready, rsp_valid, rsp_data, bank_en, clear_busy
    );
endinterface

// File: rtl/sram_bank_buf.sv
// Banked single-port SRAM buffer with a pipelined read path and a row-parallel zero-fill.
// Zero-fill writes one row in every bank per cycle, so it takes BANK_DEPTH cycles.
module sram_bank_buf #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 12,
    parameter int NUM_BANKS      = 4,
    parameter int READ_LAT       = 1,
    parameter int INTERLEAVE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic           clk,
    input logic           reset,
    sram_bank_buf_if.slave bus
);
    localparam int BANK_W     = $clog2(NUM_BANKS);
    localparam int BSEL_W     = (BANK_W > 0) ? BANK_W : 1;
    localparam int ROW_W      = ADDR_W - BANK_W;
    localparam int BANK_DEPTH = (1 << ADDR_W) / NUM_BANKS;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ROW_W-1:0]    row_r;
    logic [BSEL_W-1:0]   bank_s;
    logic [ROW_W-1:0]    row_s;
    logic                accept_s;
    logic                rd_acc_s;
    logic                wr_acc_s;
    logic [DATA_W-1:0]   mem [NUM_BANKS][BANK_DEPTH];
    logic [READ_LAT-1:0] pipe_v_r;
    logic [DATA_W-1:0]   pipe_d_r [READ_LAT];

    // Address split into bank select and row within the bank
    always_comb begin
        if (INTERLEAVE != 0) begin
            bank_s = BSEL_W'(bus.req_addr);
            row_s  = ROW_W'(bus.req_addr >> BANK_W);
        end else begin
            bank_s = BSEL_W'(bus.req_addr >> ROW_W);
            row_s  = bus.req_addr[ROW_W-1:0];
        end
    end

    // Handshake, status and bank activity enables
    always_comb begin
        bus.req_ready  = (state_r == ST_RUN) && !bus.clear_start;
        bus.clear_busy = (state_r == ST_CLEAR);
        accept_s       = bus.req_valid && bus.req_ready;
        rd_acc_s       = accept_s && !bus.req_we;
        wr_acc_s       = accept_s && bus.req_we;
        bus.bank_en    = '0;
        if (state_r == ST_CLEAR) begin
            bus.bank_en = '1;
        end else if (accept_s) begin
            bus.bank_en = NUM_BANKS'(1) << bank_s;
        end else begin
            bus.bank_en = '0;
        end
    end

    // Next-state logic: fill ends on the last row, clear_start only honoured in RUN
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (row_r == ROW_W'(BANK_DEPTH - 1)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (bus.clear_start) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fill row counter; parked at zero outside CLEAR so a new fill starts at row 0
    always_ff @(posedge clk) begin
        if (reset) begin
            row_r <= '0;
        end else if (state_r == ST_CLEAR) begin
            row_r <= row_r + ROW_W'(1);
        end else begin
            row_r <= '0;
        end
    end

    // Storage: no reset so contents survive reset when the fill is disabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_CLEAR) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    mem[b][row_r] <= '0;
                end
            end else if (wr_acc_s) begin
                mem[bank_s][row_s] <= bus.req_wdata;
            end
        end
    end

    // Read pipeline: stage 0 samples the array at the accept edge; data stages
    // only advance behind a valid so the last stage holds between responses
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v_r <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_d_r[i] <= '0;
            end
        end else begin
            pipe_v_r[0] <= rd_acc_s;
            if (rd_acc_s) begin
                pipe_d_r[0] <= mem[bank_s][row_s];
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                if (pipe_v_r[i-1]) begin
                    pipe_d_r[i] <= pipe_d_r[i-1];
                end
            end
        end
    end

    assign bus.rsp_valid = pipe_v_r[READ_LAT-1];
    assign bus.rsp_data  = pipe_d_r[READ_LAT-1];
endmodule

// File: tb/tb_sram_bank_buf.sv
// Directed bench for sram_bank_buf: three configurations share one stimulus stream
// (defaults, interleaved decode, and 3-cycle latency without fill-on-reset).
module tb_sram_bank_buf;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic       clear_start = 1'b0;
    logic [11:0] req_addr = 12'd0;
    logic [7:0]  req_wdata = 8'd0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_bank_buf_if #(.DATA_W(8), .ADDR_W(12), .NUM_BANKS(4)) if_def ();
    sram_bank_buf_if #(.DATA_W(8), .ADDR_W(12), .NUM_BANKS(4)) if_il ();
    sram_bank_buf_if #(.DATA_W(8), .ADDR_W(12), .NUM_BANKS(4)) if_l3 ();

    assign if_def.req_valid = req_valid; assign if_def.req_we = req_we; assign if_def.req_addr = req_addr;
    assign if_def.req_wdata = req_wdata; assign if_def.clear_start = clear_start;
    assign if_il.req_valid = req_valid;  assign if_il.req_we = req_we;  assign if_il.req_addr = req_addr;
    assign if_il.req_wdata = req_wdata;  assign if_il.clear_start = clear_start;
    assign if_l3.req_valid = req_valid;  assign if_l3.req_we = req_we;  assign if_l3.req_addr = req_addr;
    assign if_l3.req_wdata = req_wdata;  assign if_l3.clear_start = clear_start;

    sram_bank_buf u_def (.clk(clk), .reset(reset), .bus(if_def.slave));
    sram_bank_buf #(.INTERLEAVE(1)) u_il (.clk(clk), .reset(reset), .bus(if_il.slave));
    sram_bank_buf #(.READ_LAT(3), .CLEAR_ON_RESET(0)) u_l3 (.clk(clk), .reset(reset), .bus(if_l3.slave));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we = 1'b0;
        clear_start = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        reset = 1'b1; idle(); cyc(); reset = 1'b0;
        checks++; if (if_def.clear_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b exp 1", if_def.clear_busy); end
        checks++; if (if_def.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", if_def.req_ready); end
        checks++; if (if_def.bank_en !== 4'b1111) begin errors++; $display("FAIL reset_bank_en got %0b exp 1111", if_def.bank_en); end
        checks++; if (if_def.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", if_def.rsp_valid); end
        checks++; if (if_def.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %0h exp 0", if_def.rsp_data); end
        checks++; if (if_l3.clear_busy !== 1'b0) begin errors++; $display("FAIL noclr_busy got %0b exp 0", if_l3.clear_busy); end
        checks++; if (if_l3.req_ready !== 1'b1) begin errors++; $display("FAIL noclr_ready got %0b exp 1", if_l3.req_ready); end
        n = 0; bad = 0;
        while (if_def.clear_busy === 1'b1 && n < 2000) begin
            if (if_def.req_ready !== 1'b0) bad++;
            n++;
            cyc();
        end
        checks++; if (n !== 1024) begin errors++; $display("FAIL fill_cycles got %0d exp 1024", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL fill_ready_low got %0d exp 0", bad); end
        checks++; if (if_def.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_fill got %0b exp 1", if_def.req_ready); end
        checks++; if (if_il.clear_busy !== 1'b0) begin errors++; $display("FAIL il_busy_after_fill got %0b exp 0", if_il.clear_busy); end
    endtask

    task automatic test_read_after_clear();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'd2058;
        cyc(); idle();
        checks++; if (if_def.rsp_valid !== 1'b1) begin errors++; $display("FAIL clr_read_valid got %0b exp 1", if_def.rsp_valid); end
        checks++; if (if_def.rsp_data !== 8'h00) begin errors++; $display("FAIL clr_read_data got %0h exp 0", if_def.rsp_data); end
    endtask

    task automatic test_write_read();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'd2058; req_wdata = 8'd50; #1;
        checks++; if (if_def.bank_en !== 4'b0100) begin errors++; $display("FAIL wr_bank_en got %0b exp 0100", if_def.bank_en); end
        checks++; if (if_il.bank_en !== 4'b0100) begin errors++; $display("FAIL il_wr_bank_en got %0b exp 0100", if_il.bank_en); end
        cyc(); req_we = 1'b0; #1;
        checks++; if (if_def.bank_en !== 4'b0100) begin errors++; $display("FAIL rd_bank_en got %0b exp 0100", if_def.bank_en); end
        cyc(); idle();
        checks++; if (if_def.rsp_valid !== 1'b1) begin errors++; $display("FAIL raw_valid got %0b exp 1", if_def.rsp_valid); end
        checks++; if (if_def.rsp_data !== 8'd50) begin errors++; $display("FAIL raw_data got %0d exp 50", if_def.rsp_data); end
        #1;
        checks++; if (if_def.bank_en !== 4'b0000) begin errors++; $display("FAIL idle_bank_en got %0b exp 0000", if_def.bank_en); end
        cyc();
        checks++; if (if_def.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %0b exp 0", if_def.rsp_valid); end
        checks++; if (if_def.rsp_data !== 8'd50) begin errors++; $display("FAIL rsp_hold got %0d exp 50", if_def.rsp_data); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a [3];
        logic [3:0]  il_en [3];
        a = '{12'd2072, 12'd2058, 12'd2062};
        il_en = '{4'b0001, 4'b0100, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = a[i]; req_wdata = 8'd40; #1;
            checks++; if (if_il.bank_en !== il_en[i]) begin errors++; $display("FAIL b2b_il_en[%0d] got %0b exp %0b", i, if_il.bank_en, il_en[i]); end
            checks++; if (if_def.bank_en !== 4'b0100) begin errors++; $display("FAIL b2b_def_en[%0d] got %0b exp 0100", i, if_def.bank_en); end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            req_we = 1'b0; req_addr = a[i];
            cyc();
            checks++; if (if_def.rsp_valid !== 1'b1 || if_def.rsp_data !== 8'd40) begin errors++; $display("FAIL b2b_rsp[%0d] got %0b/%0d exp 1/40", i, if_def.rsp_valid, if_def.rsp_data); end
            checks++; if (if_il.rsp_data !== 8'd40) begin errors++; $display("FAIL b2b_il_rsp[%0d] got %0d exp 40", i, if_il.rsp_data); end
        end
        idle(); cyc();
        checks++; if (if_def.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b exp 0", if_def.rsp_valid); end
    endtask

    task automatic test_bank_decode();
        logic [11:0] a [7];
        logic [7:0]  d [7];
        logic [3:0]  de [7];
        logic [3:0]  ie [7];
        a  = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'h001, 12'h002, 12'h003};
        d  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        de = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
        ie = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = a[i]; req_wdata = d[i]; #1;
            checks++; if (if_def.bank_en !== de[i]) begin errors++; $display("FAIL dec_def_en[%0d] got %0b exp %0b", i, if_def.bank_en, de[i]); end
            checks++; if (if_il.bank_en !== ie[i]) begin errors++; $display("FAIL dec_il_en[%0d] got %0b exp %0b", i, if_il.bank_en, ie[i]); end
            cyc();
        end
        for (int i = 0; i < 7; i++) begin
            req_we = 1'b0; req_addr = a[i];
            cyc();
            checks++; if (if_def.rsp_data !== d[i]) begin errors++; $display("FAIL dec_def_rd[%0d] got %0h exp %0h", i, if_def.rsp_data, d[i]); end
            checks++; if (if_il.rsp_data !== d[i]) begin errors++; $display("FAIL dec_il_rd[%0d] got %0h exp %0h", i, if_il.rsp_data, d[i]); end
        end
        idle();
    endtask

    task automatic test_pipeline_lat3();
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 12'(i); req_wdata = 8'(10 + i);
            cyc();
        end
        for (int j = 0; j < 12; j++) begin
            if (j < 8) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 12'(j);
            end else begin
                idle();
            end
            cyc();
            checks++; if (if_l3.rsp_valid !== ((j >= 2) && (j < 10))) begin errors++; $display("FAIL l3_valid[%0d] got %0b", j, if_l3.rsp_valid); end
            if ((j >= 2) && (j < 10)) begin
                checks++; if (if_l3.rsp_data !== 8'(8 + j)) begin errors++; $display("FAIL l3_data[%0d] got %0d exp %0d", j, if_l3.rsp_data, 8 + j); end
            end
            if (j < 8) begin
                checks++; if (if_def.rsp_valid !== 1'b1 || if_def.rsp_data !== 8'(10 + j)) begin errors++; $display("FAIL l1_pipe[%0d] got %0b/%0d exp 1/%0d", j, if_def.rsp_valid, if_def.rsp_data, 10 + j); end
            end
        end
    endtask

    task automatic test_clear_start();
        int n;
        int bad;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'd5; req_wdata = 8'h5A;
        cyc();
        req_we = 1'b0;
        cyc();
        idle(); clear_start = 1'b1; #1;
        checks++; if (if_def.req_ready !== 1'b0) begin errors++; $display("FAIL cs_ready got %0b exp 0", if_def.req_ready); end
        checks++; if (if_def.rsp_valid !== 1'b1 || if_def.rsp_data !== 8'h5A) begin errors++; $display("FAIL cs_l1_rsp got %0b/%0h exp 1/5a", if_def.rsp_valid, if_def.rsp_data); end
        cyc(); clear_start = 1'b0;
        checks++; if (if_def.clear_busy !== 1'b1) begin errors++; $display("FAIL cs_busy got %0b exp 1", if_def.clear_busy); end
        checks++; if (if_l3.rsp_valid !== 1'b0) begin errors++; $display("FAIL cs_l3_early got %0b exp 0", if_l3.rsp_valid); end
        n = 1; bad = 0;
        cyc();
        checks++; if (if_l3.rsp_valid !== 1'b1 || if_l3.rsp_data !== 8'h5A) begin errors++; $display("FAIL cs_l3_inflight got %0b/%0h exp 1/5a", if_l3.rsp_valid, if_l3.rsp_data); end
        while (if_def.clear_busy === 1'b1 && n < 3000) begin
            if (if_def.req_ready !== 1'b0) bad++;
            n++;
            cyc();
        end
        checks++; if (n !== 1024) begin errors++; $display("FAIL cs_cycles got %0d exp 1024", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL cs_ready_low got %0d exp 0", bad); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'd5;
        cyc(); idle();
        checks++; if (if_def.rsp_valid !== 1'b1 || if_def.rsp_data !== 8'h00) begin errors++; $display("FAIL cs_cleared got %0b/%0h exp 1/0", if_def.rsp_valid, if_def.rsp_data); end
        cyc(); cyc();
        checks++; if (if_l3.rsp_valid !== 1'b1 || if_l3.rsp_data !== 8'h00) begin errors++; $display("FAIL cs_l3_cleared got %0b/%0h exp 1/0", if_l3.rsp_valid, if_l3.rsp_data); end
    endtask

    task automatic test_reset_flush();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'd9; req_wdata = 8'h3C;
        cyc();
        req_we = 1'b0;
        cyc(); cyc();
        idle(); reset = 1'b1;
        cyc(); reset = 1'b0;
        checks++; if (if_l3.rsp_valid !== 1'b0 || if_l3.rsp_data !== 8'h00) begin errors++; $display("FAIL flush_rst got %0b/%0h exp 0/0", if_l3.rsp_valid, if_l3.rsp_data); end
        checks++; if (if_l3.clear_busy !== 1'b0 || if_l3.req_ready !== 1'b1) begin errors++; $display("FAIL noclr_rst got %0b/%0b exp 0/1", if_l3.clear_busy, if_l3.req_ready); end
        checks++; if (if_def.clear_busy !== 1'b1) begin errors++; $display("FAIL def_rst_busy got %0b exp 1", if_def.clear_busy); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++; if (if_l3.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet[%0d] got %0b exp 0", k, if_l3.rsp_valid); end
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'd9;
        cyc(); idle(); cyc(); cyc();
        checks++; if (if_l3.rsp_valid !== 1'b1 || if_l3.rsp_data !== 8'h3C) begin errors++; $display("FAIL preserve got %0b/%0h exp 1/3c", if_l3.rsp_valid, if_l3.rsp_data); end
    endtask

    task automatic test_reset_during_clear();
        int n;
        reset = 1'b1; cyc(); reset = 1'b0;
        n = 0;
        while (if_def.clear_busy === 1'b1 && n < 2000) begin
            n++;
            cyc();
        end
        checks++; if (n !== 1024) begin errors++; $display("FAIL refill_cycles got %0d exp 1024", n); end
        checks++; if (if_l3.clear_busy !== 1'b0) begin errors++; $display("FAIL l3_no_fill got %0b exp 0", if_l3.clear_busy); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_after_clear();
        test_write_read();
        test_back_to_back();
        test_bank_decode();
        test_pipeline_lat3();
        test_clear_start();
        test_reset_flush();
        test_reset_during_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
